// File: rtl/cdc_pkg.sv
// Shared types and constants for the req/ack clock-domain-crossing blocks.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } cdc_tx_state_t;

    localparam int CDC_SYNC_STAGES_DEF = 2;
    localparam int CDC_XFER_CNT_W      = 16;

endpackage

// File: rtl/cdc_tx_ctrl_if.sv
// Producer port plus crossing bus of the CDC source sequencer.
// The controller uses the slave modport; the producer/far-side model uses master.
interface cdc_tx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             xreq;
    logic [WIDTH-1:0] xdata;
    logic             xack_async;

    modport master (
        output in_valid, in_data, xack_async,
        input  in_ready, xreq, xdata
    );

    modport slave (
        input  in_valid, in_data, xack_async,
        output in_ready, xreq, xdata
    );
endinterface

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer, async active-low reset to 0.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chain <= '0;
        else      chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/cdc_tx_ctrl.sv
// Source-side four-phase req/ack sequencer for a multi-bit CDC bus.
// Optional REQ timeout with sticky err is enabled by defining CDC_TX_TIMEOUT_EN.
module cdc_tx_ctrl
    import cdc_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = CDC_SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    cdc_tx_ctrl_if.slave              bus,
    output logic                      busy,
    output logic [CDC_XFER_CNT_W-1:0] xfer_cnt,
    output logic                      err,
    input  logic                      err_clr
);
    cdc_tx_state_t    state;
    logic             ack_s;
    logic             accept;
    logic             tmo;
    logic             xreq_q;
    logic             ready_q;
    logic [WIDTH-1:0] xdata_q;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.xack_async),
        .q   (ack_s)
    );

    // ready_q is only ever high in IDLE, so it doubles as the state qualifier
    assign accept = (state == IDLE) && ready_q && bus.in_valid;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_cnt;

    assign tmo = (state == REQ) && !ack_s && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (accept)              tmo_cnt <= '0;
            else if (state == REQ)   tmo_cnt <= tmo_cnt + 1'b1;
            // a timeout on the same edge as a clear keeps the flag set
            if (tmo)                 err <= 1'b1;
            else if (err_clr)        err <= 1'b0;
        end
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            xreq_q   <= 1'b0;
            xdata_q  <= '0;
            ready_q  <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        xdata_q <= bus.in_data;
                        xreq_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        xreq_q   <= 1'b0;
                        xfer_cnt <= xfer_cnt + 1'b1;
                        state    <= REL;
                    end else if (tmo) begin
                        xreq_q <= 1'b0;
                        state  <= REL;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    xreq_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.xreq     = xreq_q;
    assign bus.xdata    = xdata_q;
    assign bus.in_ready = ready_q;
    assign busy         = (state != IDLE);
endmodule
